// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator feeding a DEPTH-entry result FIFO.
// Ports: clk, rst_n (async, active-low), flush; request side in_valid/in_ready,
//   in_inst, in_imm_op, in_tag; result side out_valid/out_ready, out_imm,
//   out_tag, out_err; err_cnt only when IMM_GEN_ERRCNT_EN is defined.
// Formats (in_imm_op): 000 none, 001 I, 010 S, 011 U, 100 J, 101 B,
//   110 Z (rs1 field zero-extended), 111 illegal (imm 0, out_err set).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
`ifdef IMM_GEN_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_I    = 3'b001;
  localparam logic [2:0] OP_S    = 3'b010;
  localparam logic [2:0] OP_U    = 3'b011;
  localparam logic [2:0] OP_J    = 3'b100;
  localparam logic [2:0] OP_B    = 3'b101;
  localparam logic [2:0] OP_Z    = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic             r_err [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;

  logic [63:0]      w_imm64;
  logic             w_ill;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_unused_ok;

  // Built at 64 bits and truncated, so both XLEN values share one decoder.
  always_comb begin
    w_imm64 = '0;
    w_ill   = 1'b0;
    unique case (in_imm_op)
      OP_NONE: w_imm64 = '0;
      OP_I: w_imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
      OP_S: w_imm64 = {{52{in_inst[31]}}, in_inst[31:25],
                       in_inst[11:7]};
      OP_U: w_imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'h000};
      OP_J: w_imm64 = {{43{in_inst[31]}}, in_inst[31],
                       in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
      OP_B: w_imm64 = {{51{in_inst[31]}}, in_inst[31],
                       in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
      OP_Z: w_imm64 = {59'h0, in_inst[19:15]};
      OP_ILL: w_ill = 1'b1;
    endcase
  end

  assign w_unused_ok = ^{in_inst[6:0], w_imm64};

  assign w_empty  = (r_cnt == '0);
  // Never looks at out_ready: a full FIFO refuses even while draining.
  // Held high during flush since any same-cycle accept is discarded anyway.
  assign in_ready = (r_cnt < L_DEPTH) | flush;
  assign w_push   = in_valid & in_ready & ~flush;
  assign w_pop    = out_valid & out_ready & ~flush;

  assign out_valid = ~w_empty;
  assign out_imm   = w_empty ? '0 : r_imm[r_rd];
  assign out_tag   = w_empty ? '0 : r_tag[r_rd];
  assign out_err   = w_empty ? 1'b0 : r_err[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_imm[i] <= '0;
        r_tag[i] <= '0;
        r_err[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_imm[r_wr] <= w_imm64[XLEN-1:0];
      r_tag[r_wr] <= in_tag;
      r_err[r_wr] <= w_ill;
    end
  end

`ifdef IMM_GEN_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Flush does not clear it; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_push && w_ill && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe (XLEN 32 and 64 instances).
// Inputs change 1ns after rising edges; outputs sampled at that point.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;
  logic        out_err;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;
  logic        out_err64;

`ifdef IMM_GEN_ERRCNT_EN
  logic [15:0] err_cnt;
  logic [15:0] err_cnt64;
`endif

  int total;
  int bad;

  imm_gen_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_imm_op(in_imm_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
`ifdef IMM_GEN_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_imm_op(in_imm_op), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
`ifdef IMM_GEN_ERRCNT_EN
    , .err_cnt(err_cnt64)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [2:0] op,
                      input logic [4:0] tag);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_imm_op = op;
    in_tag    = tag;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%0h exp=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_ready got=%0h exp=1", in_ready);
    end
    total++;
    if (out_imm !== 32'h0 || out_tag !== 5'h0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_outs got imm=%h tag=%h err=%h exp=0/0/0",
               out_imm, out_tag, out_err);
    end
`ifdef IMM_GEN_ERRCNT_EN
    total++;
    if (err_cnt !== 16'h0) begin
      bad++;
      $display("FAIL rst_errcnt got=%h exp=0", err_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] insts [7] = '{32'hFFF00093, 32'h00A12223, 32'hFE000EE3,
                               32'h123450B7, 32'h0080006F, 32'h000F8000,
                               32'hFFFFFFFF};
    logic [2:0]  ops   [7] = '{3'b001, 3'b010, 3'b101, 3'b011,
                               3'b100, 3'b110, 3'b000};
    logic [31:0] exps  [7] = '{32'hFFFFFFFF, 32'h00000004, 32'hFFFFFFFC,
                               32'h12345000, 32'h00000008, 32'h0000001F,
                               32'h00000000};
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_inst   = insts[i];
      in_imm_op = ops[i];
      in_tag    = 5'(i + 1);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL fmt%0d_nobypass valid got=%0h exp=0", i, out_valid);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_imm !== exps[i] ||
          out_tag !== 5'(i + 1) || out_err !== 1'b0) begin
        bad++;
        $display("FAIL fmt%0d got v=%0h imm=%h tag=%0d err=%0h exp 1/%h/%0d/0",
                 i, out_valid, out_imm, out_tag, out_err, exps[i], i + 1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_tag !== 5'h0) begin
        bad++;
        $display("FAIL fmt%0d_empty got v=%0h imm=%h tag=%0d exp 0/0/0",
                 i, out_valid, out_imm, out_tag);
      end
    end
  endtask

  task automatic test_xlen64();
    out_ready = 1'b0;
    push(32'h80000037, 3'b011, 5'd7);
    total++;
    if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFF80000000) begin
      bad++;
      $display("FAIL x64_u got v=%0h imm=%h exp 1/ffffffff80000000",
               out_valid64, out_imm64);
    end
    total++;
    if (out_imm !== 32'h80000000) begin
      bad++;
      $display("FAIL x32_u got=%h exp=80000000", out_imm);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h00100093 + (32'(i) << 20), 3'b001, 5'(i));
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got=%0h exp=0", in_ready);
    end
    tick();
    tick();
    total++;
    if (out_tag !== 5'd0 || out_imm !== 32'h1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL full_hold got tag=%0d imm=%h v=%0h exp 0/1/1",
               out_tag, out_imm, out_valid);
    end
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    in_imm_op = 3'b001;
    in_tag    = 5'd9;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready_pop got=%0h exp=0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int t = 1; t < 4; t++) begin
      total++;
      if (out_valid !== 1'b1 || out_tag !== 5'(t) ||
          out_imm !== 32'(t + 1)) begin
        bad++;
        $display("FAIL drain%0d got v=%0h tag=%0d imm=%h exp 1/%0d/%0h",
                 t, out_valid, out_tag, out_imm, t, t + 1);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_end got v=%0h tag=%0d exp v=0",
               out_valid, out_tag);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_imm_op = 3'b110;
    for (int k = 0; k < 5; k++) begin
      in_inst = 32'(k) << 15;
      in_tag  = 5'(10 + k);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_tag !== 5'(10 + k) ||
          out_imm !== 32'(k)) begin
        bad++;
        $display("FAIL b2b%0d got v=%0h tag=%0d imm=%h exp 1/%0d/%0h",
                 k, out_valid, out_tag, out_imm, 10 + k, k);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got v=%0h exp 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'hFFFFFFFF, 3'b111, 5'(i + 1));
    end
    total++;
    if (out_valid !== 1'b1 || out_imm !== 32'h0 || out_err !== 1'b1 ||
        out_tag !== 5'd1) begin
      bad++;
      $display("FAIL ill got v=%0h imm=%h err=%0h tag=%0d exp 1/0/1/1",
               out_valid, out_imm, out_err, out_tag);
    end
`ifdef IMM_GEN_ERRCNT_EN
    total++;
    if (err_cnt !== 16'd3) begin
      bad++;
      $display("FAIL ill_cnt got=%0d exp=3", err_cnt);
    end
`endif
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    in_imm_op = 3'b001;
    in_tag    = 5'd30;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_ready got=%0h exp=1", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_imm !== 32'h0) begin
      bad++;
      $display("FAIL flush_empty got v=%0h imm=%h exp 0/0",
               out_valid, out_imm);
    end
`ifdef IMM_GEN_ERRCNT_EN
    total++;
    if (err_cnt !== 16'd3) begin
      bad++;
      $display("FAIL flush_cnt got=%0d exp=3", err_cnt);
    end
`endif
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop got v=%0h tag=%0d exp v=0",
               out_valid, out_tag);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'hFFF00093, 3'b001, 5'(i + 1));
    end
    total++;
    if (out_valid !== 1'b1 || out_tag !== 5'd1) begin
      bad++;
      $display("FAIL mrst_pre got v=%0h tag=%0d exp 1/1",
               out_valid, out_tag);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 5'd0) begin
      bad++;
      $display("FAIL mrst_now got v=%0h rdy=%0h tag=%0d exp 0/1/0",
               out_valid, in_ready, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(32'h123450B7, 3'b011, 5'd21);
    total++;
    if (out_valid !== 1'b1 || out_tag !== 5'd21 ||
        out_imm !== 32'h12345000) begin
      bad++;
      $display("FAIL mrst_first got v=%0h tag=%0d imm=%h exp 1/21/12345000",
               out_valid, out_tag, out_imm);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_imm_op = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    test_reset();
    test_formats();
    test_xlen64();
    test_full();
    test_back_to_back();
    test_illegal();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
